// File: rtl/opcode_fetch.sv
// Opcode prefetch: fetches 32-bit little-endian words into a byte queue and presents the head byte to the sequencer. Optional macro OPCODE_FETCH_BYPASS_EN.
// Latency: bytes are visible the cycle after fe__rvalid; with OPCODE_FETCH_BYPASS_EN a cold queue shows byte[skip] in the rvalid cycle.
// Backpressure: mc__more holds the head; a fetch is issued only with 4 free slots; one request outstanding; redirect stalls for one cycle.
module opcode_fetch #(
    parameter int                QDEPTH   = 8,
    parameter int                ADDR_W   = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_b,
    output logic              fe__req,
    output logic [ADDR_W-1:0] fe__addr,
    input  logic              fe__gnt,
    input  logic [31:0]       fe__rdata,
    input  logic              fe__rvalid,
    input  logic              br__redirect,
    input  logic [ADDR_W-1:0] br__target,
    input  logic              mc__more,
    output logic [7:0]        opcode,
    output logic [ADDR_W-1:0] op_pc,
    output logic              mc__stall
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [7:0]        q [QDEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, count_nxt;
    logic [ADDR_W-1:0] fetch_addr, pc;
    logic [1:0]        skip;

    logic              empty, room, resp, bypass;
    logic              pop, pop_q, pop_byp;
    logic [2:0]        start, enq_n;
    logic [7:0]        resp_byte;
    logic [7:0]        wbyte [4];
    logic [1:0]        wsel [4];
    logic [3:0]        wen;

    assign room     = (count + CW'(4)) <= CW'(QDEPTH);
    assign fe__req  = (state == REQ);
    assign fe__addr = fetch_addr;
    assign op_pc    = pc;

    // Head presentation, stall, pop decision and which response bytes land in the queue.
    always_comb begin
        empty     = (count == '0);
        resp      = (state == WAIT) && fe__rvalid && !br__redirect;
        resp_byte = fe__rdata[{skip, 3'b000} +: 8];
`ifdef OPCODE_FETCH_BYPASS_EN
        bypass    = empty && (state == WAIT) && fe__rvalid;
`else
        bypass    = 1'b0;
`endif
        opcode    = bypass ? resp_byte : (empty ? 8'h00 : q[rd_ptr]);
        mc__stall = (empty && !bypass) || br__redirect;
        pop       = !mc__more && !mc__stall;
        pop_byp   = pop && bypass;
        pop_q     = pop && !bypass;
        // A bypassed pop consumes byte[skip] directly, so enqueue starts one byte later.
        start     = {1'b0, skip} + {2'b00, pop_byp};
        enq_n     = resp ? (3'd4 - start) : 3'd0;
        for (int i = 0; i < 4; i++) begin
            wsel[i]  = start[1:0] + 2'(i);
            wbyte[i] = fe__rdata[{wsel[i], 3'b000} +: 8];
            wen[i]   = (3'(i) < enq_n);
        end
        count_nxt = count + CW'(enq_n) - CW'(pop_q);
    end

    // Fetch FSM next state; redirect overrides the normal transitions.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (room)       state_nxt = REQ;
            REQ:     if (fe__gnt)    state_nxt = WAIT;
            WAIT:    if (fe__rvalid) state_nxt = IDLE;
            DRAIN:   if (fe__rvalid) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
        if (br__redirect) begin
            case (state)
                REQ:         state_nxt = fe__gnt ? DRAIN : IDLE;
                // A response arriving with the redirect is the pending one: nothing left to drain.
                WAIT, DRAIN: state_nxt = fe__rvalid ? IDLE : DRAIN;
                default:     state_nxt = IDLE;
            endcase
        end
    end

    // State register, queue pointers, fetch address, skip and opcode pc.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fetch_addr <= {RESET_PC[ADDR_W-1:2], 2'b00};
            skip       <= RESET_PC[1:0];
            pc         <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (br__redirect) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                fetch_addr <= {br__target[ADDR_W-1:2], 2'b00};
                skip       <= br__target[1:0];
                pc         <= br__target;
            end else begin
                if (pop_q) rd_ptr <= rd_ptr + PW'(1);
                wr_ptr <= wr_ptr + PW'(enq_n);
                count  <= count_nxt;
                if (state == REQ && fe__gnt) fetch_addr <= fetch_addr + ADDR_W'(4);
                if (resp) skip <= 2'b00;
                if (pop)  pc   <= pc + ADDR_W'(1);
            end
        end
    end

    // Byte storage; no reset needed because count gates what is visible.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) q[wr_ptr + PW'(i)] <= wbyte[i];
        end
    end
endmodule
